// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for a 5-stage in-order pipeline: ALU operand forwarding selects,
// load-use stall/bubble generation and a saturating stall counter.
module pipeline_hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       forward_rs1,
    output logic [1:0]       forward_rs2,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_count
);

    logic       ex_valid_q, ex_valid_d;
    logic [4:0] ex_rs1_q, ex_rs1_d;
    logic [4:0] ex_rs2_q, ex_rs2_d;
    logic       ex_uses1_q, ex_uses1_d;
    logic       ex_uses2_q, ex_uses2_d;
    logic [4:0] ex_rd_q, ex_rd_d;
    logic       ex_regwrite_q, ex_regwrite_d;
    logic       ex_memread_q, ex_memread_d;

    logic       mem_valid_q, mem_valid_d;
    logic [4:0] mem_rd_q, mem_rd_d;
    logic       mem_regwrite_q, mem_regwrite_d;
    logic       mem_memread_q, mem_memread_d;

    logic       wb_valid_q, wb_valid_d;
    logic [4:0] wb_rd_q, wb_rd_d;
    logic       wb_regwrite_q, wb_regwrite_d;

    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic mem_writes, wb_writes, ex_load_writes, hazard;

    always_comb begin
        // x0 is hardwired to zero, so a stage targeting it never produces a value.
        mem_writes     = mem_valid_q && mem_regwrite_q && (mem_rd_q != 5'd0);
        wb_writes      = wb_valid_q && wb_regwrite_q && (wb_rd_q != 5'd0);
        ex_load_writes = ex_valid_q && ex_regwrite_q && ex_memread_q && (ex_rd_q != 5'd0);

        forward_rs1 = 2'b00;
        if (ex_uses1_q && mem_writes && !mem_memread_q && (mem_rd_q == ex_rs1_q)) begin
            forward_rs1 = 2'b01;
        end else if (ex_uses1_q && wb_writes && (wb_rd_q == ex_rs1_q)) begin
            forward_rs1 = 2'b10;
        end

        forward_rs2 = 2'b00;
        if (ex_uses2_q && mem_writes && !mem_memread_q && (mem_rd_q == ex_rs2_q)) begin
            forward_rs2 = 2'b01;
        end else if (ex_uses2_q && wb_writes && (wb_rd_q == ex_rs2_q)) begin
            forward_rs2 = 2'b10;
        end

        // WB is not checked: the register file writes before it reads.
        hazard = id_valid && ex_load_writes &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd_q)) || (id_uses_rs2 && (id_rs2 == ex_rd_q)));

        stall  = hazard && !flush;
        bubble = stall || flush;
    end

    always_comb begin
        ex_valid_d    = id_valid;
        ex_rs1_d      = id_rs1;
        ex_rs2_d      = id_rs2;
        ex_uses1_d    = id_uses_rs1;
        ex_uses2_d    = id_uses_rs2;
        ex_rd_d       = id_rd;
        ex_regwrite_d = id_regwrite;
        ex_memread_d  = id_memread;
        if (bubble) begin
            // A bubble must neither produce nor consume a forwarded value.
            ex_valid_d    = 1'b0;
            ex_uses1_d    = 1'b0;
            ex_uses2_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
        end

        mem_valid_d    = ex_valid_q;
        mem_rd_d       = ex_rd_q;
        mem_regwrite_d = ex_regwrite_q;
        mem_memread_d  = ex_memread_q;

        wb_valid_d    = mem_valid_q;
        wb_rd_d       = mem_rd_q;
        wb_regwrite_d = mem_regwrite_q;

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_q       <= 5'd0;
            ex_rs2_q       <= 5'd0;
            ex_uses1_q     <= 1'b0;
            ex_uses2_q     <= 1'b0;
            ex_rd_q        <= 5'd0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= 5'd0;
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_regwrite_q  <= 1'b0;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_uses1_q     <= ex_uses1_d;
            ex_uses2_q     <= ex_uses2_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_valid_q    <= mem_valid_d;
            mem_rd_q       <= mem_rd_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_memread_q  <= mem_memread_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_regwrite_q  <= wb_regwrite_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
